// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
// Data-memory port between the RV32I core and the data-side responder.
// The core drives one access per cycle from its EX stage and samples the
// load result in its MA stage, one cycle later.
//   addr_i       byte address of the access
//   wr_data_i    store data, sub-word value in the low bits
//   memwrite_i   store request this cycle
//   memread_i    load request this cycle
//   sign_mask_i  [1:0] size (byte/half/word), [2] zero-extend, [3] unused
//   rd_data_o    load result for the access made in the previous cycle
interface data_mem_responder_if;
    logic [31:0] addr_i;
    logic [31:0] wr_data_i;
    logic        memwrite_i;
    logic        memread_i;
    logic [3:0]  sign_mask_i;
    logic [31:0] rd_data_o;

    modport master (
        output addr_i, wr_data_i, memwrite_i, memread_i, sign_mask_i,
        input  rd_data_o
    );

    modport slave (
        input  addr_i, wr_data_i, memwrite_i, memread_i, sign_mask_i,
        output rd_data_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Data-side memory responder for the five-stage RV32I core. Serves one load
// or store per cycle from a synchronous word-wide RAM with byte-lane writes,
// or from a 16-byte MMIO window (LED, cycle counter, error status, reserved).
// Load data is aligned and extended and appears one cycle after the request.
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   bus        data-memory port (slave side)
//   led_o      LED register contents
//   err_o      sticky access-error flag
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_2000
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    data_mem_responder_if.slave  bus,
    output logic [7:0]           led_o,
    output logic                 err_o
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] ram_q;

    logic [1:0]  size;
    logic        in_ram, in_mmio, misaligned, legal;
    logic        access_err, do_store, do_load, status_clear;
    logic [3:0]  be;
    logic [31:0] wdata, mmio_rdata;
    logic [AW-1:0] word_idx;

    logic [31:0] counter_q;
    logic [7:0]  led_q;
    logic        err_q;

    logic        load_q, mmio_sel_q, unsigned_q;
    logic [1:0]  size_q, off_q;
    logic [31:0] mmio_q;

    logic [31:0] raw, shifted, rd_data;
    logic        unused_bits;

    // Bit 3 of the access type is reserved and has no effect.
    assign unused_bits = bus.sign_mask_i[3];
    assign word_idx    = bus.addr_i[AW+1:2];

    // Decode the current access: region, alignment, legality, lanes, data.
    // A simultaneous read+write still stores (when legal) but is an error
    // and never produces load data.
    always_comb begin
        size       = bus.sign_mask_i[1:0];
        in_ram     = {1'b0, bus.addr_i} < RAM_BYTES;
        in_mmio    = bus.addr_i[31:4] == MMIO_BASE[31:4];
        misaligned = ((size == 2'b01) && bus.addr_i[0]) ||
                     (size[1] && (bus.addr_i[1:0] != 2'b00));
        legal      = (in_ram || in_mmio) && !misaligned;
        access_err = (bus.memread_i || bus.memwrite_i) &&
                     (!legal || (bus.memread_i && bus.memwrite_i));
        do_store   = bus.memwrite_i && legal;
        do_load    = bus.memread_i && !bus.memwrite_i && legal;

        case (size)
            2'b00:   be = 4'b0001 << bus.addr_i[1:0];
            2'b01:   be = 4'b0011 << {bus.addr_i[1], 1'b0};
            default: be = 4'b1111;
        endcase

        case (size)
            2'b00:   wdata = {4{bus.wr_data_i[7:0]}};
            2'b01:   wdata = {2{bus.wr_data_i[15:0]}};
            default: wdata = bus.wr_data_i;
        endcase

        status_clear = do_store && in_mmio && (bus.addr_i[3:2] == 2'b10) &&
                       be[0] && bus.wr_data_i[0];

        case (bus.addr_i[3:2])
            2'b00:   mmio_rdata = {24'b0, led_q};
            2'b01:   mmio_rdata = counter_q;
            2'b10:   mmio_rdata = {31'b0, err_q};
            default: mmio_rdata = 32'b0;
        endcase
    end

    // RAM array: byte-lane writes and a registered read. A load issued the
    // cycle after a store to the same word sees the new bytes because the
    // write lands on the edge before the read.
    always_ff @(posedge clk_i) begin
        if (do_store && in_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (do_load && in_ram) ram_q <= mem[word_idx];
    end

    // MMIO registers and the error flag. Setting wins over clearing, which
    // only matters for a read+write to the status register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            counter_q <= 32'b0;
            led_q     <= 8'b0;
            err_q     <= 1'b0;
        end else begin
            counter_q <= counter_q + 32'd1;
            if (do_store && in_mmio && (bus.addr_i[3:2] == 2'b00) && be[0])
                led_q <= wdata[7:0];
            if (access_err)
                err_q <= 1'b1;
            else if (status_clear)
                err_q <= 1'b0;
        end
    end

    // Load control travelling with the RAM read into the response cycle.
    // MMIO data is captured here so the counter value is that of the
    // request cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            load_q     <= 1'b0;
            mmio_sel_q <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            mmio_q     <= 32'b0;
        end else begin
            load_q <= do_load;
            if (do_load) begin
                mmio_sel_q <= in_mmio;
                unsigned_q <= bus.sign_mask_i[2];
                size_q     <= size;
                off_q      <= bus.addr_i[1:0];
                mmio_q     <= mmio_rdata;
            end
        end
    end

    // Response cycle: pick the source, shift the addressed lane down to bit 0
    // and extend it. Anything but a legal load last cycle returns zero.
    always_comb begin
        raw     = mmio_sel_q ? mmio_q : ram_q;
        shifted = raw >> {off_q, 3'b000};
        case (size_q)
            2'b00:   rd_data = unsigned_q ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   rd_data = unsigned_q ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: rd_data = raw;
        endcase
        if (!load_q) rd_data = 32'b0;
    end

    assign bus.rd_data_o = rd_data;
    assign led_o         = led_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Self-checking bench for data_mem_responder: a table of directed vectors,
// hand-written sequences for counter timing and reset, and a randomized run
// checked against a byte-level reference model of memory and MMIO state.
module tb_data_mem_responder;
    localparam int          DEPTH_WORDS = 1024;
    localparam logic [31:0] MMIO_BASE   = 32'h0000_2000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] led;
    logic       err;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .MMIO_BASE(MMIO_BASE)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .bus      (bus.slave),
        .led_o    (led),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: RAM as a byte array plus the MMIO-visible state.
    logic [7:0]  mem_b [DEPTH_WORDS*4];
    logic [7:0]  m_led;
    logic        m_err;
    logic [31:0] m_cnt;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp_rd;
        logic [7:0]  exp_led;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] mmioWord(input logic [1:0] sel);
        case (sel)
            2'd0:    return {24'b0, m_led};
            2'd1:    return m_cnt;
            2'd2:    return {31'b0, m_err};
            default: return 32'b0;
        endcase
    endfunction

    // Drive one access for one cycle, predict its outcome from the model,
    // and return with outputs settled #1 after the edge.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] m,
                                 output logic [31:0] exp_rd,
                                 output logic [7:0] exp_led,
                                 output logic exp_err);
        int          n;
        logic        is_ram, is_mmio, legal;
        logic [31:0] val, w;
        bus.memread_i   = rd;
        bus.memwrite_i  = wr;
        bus.addr_i      = a;
        bus.wr_data_i   = d;
        bus.sign_mask_i = m;

        n       = (m[1:0] == 2'b00) ? 1 : (m[1:0] == 2'b01) ? 2 : 4;
        is_ram  = a < 32'(DEPTH_WORDS*4);
        is_mmio = a[31:4] == MMIO_BASE[31:4];
        legal   = (is_ram || is_mmio) && ((a & 32'(n-1)) == 32'b0);

        val = 32'b0;
        if (rd && !wr && legal) begin
            w = mmioWord(a[3:2]);
            for (int k = 0; k < n; k++) begin
                if (is_ram) val[8*k +: 8] = mem_b[int'(a) + k];
                else        val[8*k +: 8] = w[8*(int'(a[1:0]) + k) +: 8];
            end
            if (n < 4 && !m[2] && val[8*n-1]) begin
                for (int k = n; k < 4; k++) val[8*k +: 8] = 8'hFF;
            end
        end
        exp_rd = val;

        if ((rd || wr) && (!legal || (rd && wr)))
            m_err = 1'b1;
        else if (wr && legal && is_mmio && a[3:0] == 4'h8 && d[0])
            m_err = 1'b0;
        if (wr && legal) begin
            if (is_ram) begin
                for (int k = 0; k < n; k++) mem_b[int'(a) + k] = d[8*k +: 8];
            end else if (a[3:0] == 4'h0) begin
                m_led = d[7:0];
            end
        end
        exp_led = m_led;
        exp_err = m_err;

        @(posedge clk);
        #1;
        m_cnt = m_cnt + 32'd1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] e_rd, c1, c2;
        logic [7:0]  e_led;
        logic        e_err;
        logic        rd, wr;
        logic [31:0] a;
        int          sel;

        bus.memread_i = 1'b0; bus.memwrite_i = 1'b0; bus.addr_i = 32'b0;
        bus.wr_data_i = 32'b0; bus.sign_mask_i = 4'b0;
        m_led = 8'b0; m_err = 1'b0; m_cnt = 32'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rd",  bus.rd_data_o, 32'h0);
        checkOutput("reset_led", {24'b0, led}, 32'h0);
        checkOutput("reset_err", {31'b0, err}, 32'h0);
        reset_n = 1'b1;
        m_cnt   = 32'b0;

        // rd, wr, addr, data, mask, exp_rd, exp_led, exp_err
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h10, 32'h8765_4321, 4'h2, 32'h0, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h13, 32'h0, 4'h0, 32'hFFFF_FF87, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h13, 32'h0, 4'h4, 32'h0000_0087, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h12, 32'h0, 4'h1, 32'hFFFF_8765, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h12, 32'h0, 4'h5, 32'h0000_8765, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h10, 32'h0, 4'h2, 32'h8765_4321, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h10, 32'h1122_3344, 4'h2, 32'h0, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h11, 32'h1234_56AA, 4'h0, 32'h0, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h10, 32'h0, 4'h2, 32'h1122_AA44, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h21, 32'h0, 4'h1, 32'h0, 8'h00, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h2008, 32'h1, 4'h2, 32'h0, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h2008, 32'h0, 4'h2, 32'h0, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h2000, 32'h0000_01A5, 4'h2, 32'h0, 8'hA5, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h2000, 32'h0, 4'h2, 32'h0000_00A5, 8'hA5, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 32'hFFFF_FFA5, 8'hA5, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 32'h40, 32'h55, 4'h2, 32'h0, 8'hA5, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h40, 32'h0, 4'h2, 32'h0000_0055, 8'hA5, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h2, 32'h0, 8'hA5, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h2008, 32'h1, 4'h2, 32'h0, 8'hA5, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h1000, 32'h0, 4'h2, 32'h0, 8'hA5, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h2009, 32'h1, 4'h0, 32'h0, 8'hA5, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h2008, 32'h1, 4'h1, 32'h0, 8'hA5, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h2001, 32'hFF, 4'h0, 32'h0, 8'hA5, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h2002, 32'h0, 4'h5, 32'h0, 8'hA5, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h200C, 32'h0, 4'h2, 32'h0, 8'hA5, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h2006, 32'h0, 4'h2, 32'h0, 8'hA5, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'h3, 32'h0, 8'hA5, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h20, 32'h0, 4'hB, 32'hDEAD_BEEF, 8'hA5, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h22, 32'h0, 4'h1, 32'hFFFF_DEAD, 8'hA5, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h21, 32'h0, 4'h4, 32'h0000_00BE, 8'hA5, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h2008, 32'h1, 4'h2, 32'h0, 8'hA5, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h2008, 32'h0, 4'h0, 32'h0, 8'hA5, 1'b0});

        $display("[TB] directed vectors: %0d", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                          vecs[i].mask, e_rd, e_led, e_err);
            checkOutput($sformatf("vec%0d_rd", i), bus.rd_data_o, vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d_led", i), {24'b0, led}, {24'b0, vecs[i].exp_led});
            checkOutput($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
        end

        // Cycle counter: two loads three cycles apart differ by exactly 3.
        applyStimulus(1'b1, 1'b0, MMIO_BASE + 32'h4, 32'h0, 4'h2, e_rd, e_led, e_err);
        c1 = bus.rd_data_o;
        checkOutput("cnt_first", c1, e_rd);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, e_rd, e_led, e_err);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, e_rd, e_led, e_err);
        applyStimulus(1'b1, 1'b0, MMIO_BASE + 32'h4, 32'h0, 4'h2, e_rd, e_led, e_err);
        c2 = bus.rd_data_o;
        checkOutput("cnt_delta", c2 - c1, 32'd3);

        // Reset in the cycle after a load drops everything immediately.
        applyStimulus(1'b1, 1'b0, 32'h21, 32'h0, 4'h1, e_rd, e_led, e_err);
        checkOutput("pre_reset_err", {31'b0, err}, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h2, e_rd, e_led, e_err);
        checkOutput("pre_reset_rd", bus.rd_data_o, 32'h1122_AA44);
        #2;
        reset_n = 1'b0;
        m_led   = 8'b0;
        m_err   = 1'b0;
        #1;
        checkOutput("in_reset_rd",  bus.rd_data_o, 32'h0);
        checkOutput("in_reset_led", {24'b0, led}, 32'h0);
        checkOutput("in_reset_err", {31'b0, err}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_cnt   = 32'b0;
        checkOutput("release_rd", bus.rd_data_o, 32'h0);
        applyStimulus(1'b1, 1'b0, MMIO_BASE + 32'h4, 32'h0, 4'h2, e_rd, e_led, e_err);
        checkOutput("release_cnt", bus.rd_data_o, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h2, e_rd, e_led, e_err);
        checkOutput("ram_kept", bus.rd_data_o, 32'h1122_AA44);

        // Randomized run over a small RAM window, the MMIO window and
        // unmapped space; the window is written first so every byte is known.
        for (int w = 0; w < 16; w++) begin
            applyStimulus(1'b0, 1'b1, 32'(w*4), $urandom, 4'h2, e_rd, e_led, e_err);
        end
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      a = 32'($urandom_range(0, 63));
            else if (sel < 9) a = MMIO_BASE + 32'($urandom_range(0, 15));
            else              a = 32'h1000 + 32'($urandom_range(0, 32'hFFF));
            sel = $urandom_range(0, 7);
            rd = (sel < 3) || (sel == 6);
            wr = (sel >= 3 && sel <= 6);
            applyStimulus(rd, wr, a, $urandom, 4'($urandom_range(0, 15)), e_rd, e_led, e_err);
            checkOutput($sformatf("rand%0d_rd", i), bus.rd_data_o, e_rd);
            checkOutput($sformatf("rand%0d_led", i), {24'b0, led}, {24'b0, e_led});
            checkOutput($sformatf("rand%0d_err", i), {31'b0, err}, {31'b0, e_err});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
